// File: rtl/axi_defination_pkg.sv
// Shared AXI field types for the burst address generator and its strobe decoder.
// Pure type/constant package: no logic, no latency, no flow control.
package axi_defination_pkg;

  typedef logic [31:0] axi_addr_t;
  typedef logic [7:0]  axi_length_t;
  typedef logic [3:0]  axi_wstrb_t;
  typedef logic [3:0]  axi_mid_t;

  typedef enum logic [2:0] {
    AXI_SIZE_1B   = 3'd0,
    AXI_SIZE_2B   = 3'd1,
    AXI_SIZE_4B   = 3'd2,
    AXI_SIZE_8B   = 3'd3,
    AXI_SIZE_16B  = 3'd4,
    AXI_SIZE_32B  = 3'd5,
    AXI_SIZE_64B  = 3'd6,
    AXI_SIZE_128B = 3'd7
  } axi_size_e;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_e;

  localparam int unsigned AXI_4KB_BOUNDARY = 4096;

endpackage

// File: rtl/axi_strb_calc.sv
// Byte-lane strobe decode from address lane and beat size; purely combinational (0 cycles),
// no flow control. Sizes wider than the bus saturate at the top lane.
module axi_strb_calc
  import axi_defination_pkg::*;
#(
  parameter int BUS_BYTES = 4
) (
  input  logic [$clog2(BUS_BYTES)-1:0] lane,
  input  axi_size_e                    size,
  output axi_wstrb_t                   strb
);

  localparam int LANE_W = $clog2(BUS_BYTES);

  logic [LANE_W-1:0] top_lane;

  always_comb begin
    // Last lane of the aligned container: every lane bit below the size is forced high.
    for (int j = 0; j < LANE_W; j++) begin
      top_lane[j] = lane[j] | (int'(size) > j);
    end
    strb = '0;
    for (int i = 0; i < BUS_BYTES; i++) begin
      strb[i] = (LANE_W'(i) >= lane) && (LANE_W'(i) <= top_lane);
    end
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI command into per-beat address/strobe/index; first beat 1 cycle after accept,
// beats held while beat_ready is low. AXI_ADDR_GEN_4KB_CHECK_EN adds the INCR 4KB-crossing error.
module axi_burst_addr_gen
  import axi_defination_pkg::*;
#(
  parameter int BUS_BYTES = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  axi_addr_t   cmd_addr,
  input  axi_length_t cmd_len,
  input  axi_size_e   cmd_size,
  input  axi_burst_e  cmd_burst,
  input  axi_mid_t    cmd_id,
  output logic        beat_valid,
  input  logic        beat_ready,
  output axi_addr_t   beat_addr,
  output axi_wstrb_t  beat_strb,
  output axi_mid_t    beat_id,
  output axi_length_t beat_idx,
  output logic        beat_last,
  output logic        cmd_err
);

  localparam int LANE_W = $clog2(BUS_BYTES);

  typedef enum logic {IDLE, BURST} state_e;

  state_e      state_q, state_d;
  axi_addr_t   addr_q, lo_q, hi_q, next_addr, beat_bytes;
  axi_addr_t   cmd_bytes, cmd_span, cmd_lo;
  axi_length_t len_q, idx_q;
  axi_size_e   size_q;
  axi_burst_e  burst_q;
  axi_mid_t    id_q;
  logic        err_q, err_d, last_idx, cmd_hs, beat_hs;
  axi_wstrb_t  strb_raw;
`ifdef AXI_ADDR_GEN_4KB_CHECK_EN
  axi_addr_t   cmd_last_byte;
  localparam axi_addr_t PAGE_MASK = ~axi_addr_t'(AXI_4KB_BOUNDARY - 1);
`endif

  // Command decode: span doubles as the wrap window size.
  always_comb begin
    cmd_bytes = axi_addr_t'(1) << cmd_size;
    cmd_span  = (axi_addr_t'(cmd_len) + 32'd1) << cmd_size;
    cmd_lo    = cmd_addr & ~(cmd_span - 32'd1);
    err_d     = 1'b0;
    if (int'(cmd_size) > LANE_W) err_d = 1'b1;
    if (cmd_burst == AXI_BURST_RSVD) err_d = 1'b1;
    if (cmd_burst == AXI_BURST_WRAP && !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})) err_d = 1'b1;
    if (cmd_burst == AXI_BURST_WRAP && (cmd_addr & (cmd_bytes - 32'd1)) != '0) err_d = 1'b1;
    if (cmd_burst == AXI_BURST_FIXED && cmd_len > 8'd15) err_d = 1'b1;
`ifdef AXI_ADDR_GEN_4KB_CHECK_EN
    cmd_last_byte = (cmd_addr & ~(cmd_bytes - 32'd1)) + cmd_span - 32'd1;
    if (cmd_burst == AXI_BURST_INCR && (cmd_last_byte & PAGE_MASK) != (cmd_addr & PAGE_MASK))
      err_d = 1'b1;
`endif
  end

  // Reserved burst type falls through to INCR stepping.
  always_comb begin
    beat_bytes = axi_addr_t'(1) << size_q;
    case (burst_q)
      AXI_BURST_FIXED: next_addr = addr_q;
      AXI_BURST_WRAP:  next_addr = (addr_q + beat_bytes == hi_q) ? lo_q : addr_q + beat_bytes;
      default:         next_addr = (addr_q & ~(beat_bytes - 32'd1)) + beat_bytes;
    endcase
  end

  assign last_idx = (idx_q == len_q);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    beat_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = !areset;
        if (cmd_valid && !areset) state_d = BURST;
      end
      BURST: begin
        beat_valid = 1'b1;
        if (beat_ready && last_idx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_hs  = cmd_valid && cmd_ready;
  assign beat_hs = beat_valid && beat_ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      size_q  <= AXI_SIZE_1B;
      burst_q <= AXI_BURST_FIXED;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else if (cmd_hs) begin
      addr_q  <= cmd_addr;
      lo_q    <= cmd_lo;
      hi_q    <= cmd_lo + cmd_span;
      len_q   <= cmd_len;
      idx_q   <= '0;
      size_q  <= cmd_size;
      burst_q <= cmd_burst;
      id_q    <= cmd_id;
      err_q   <= err_d;
    end else if (beat_hs && !last_idx) begin
      addr_q  <= next_addr;
      idx_q   <= idx_q + 8'd1;
    end
  end

  axi_strb_calc #(.BUS_BYTES(BUS_BYTES)) u_strb (
    .lane (addr_q[LANE_W-1:0]),
    .size (size_q),
    .strb (strb_raw)
  );

  assign beat_addr = addr_q;
  assign beat_strb = beat_valid ? strb_raw : '0;
  assign beat_id   = id_q;
  assign beat_idx  = idx_q;
  assign beat_last = beat_valid && last_idx;
  assign cmd_err   = err_q;

endmodule

// File: doc/axi_burst_addr_gen.md
AXI_BURST_ADDR_GEN -- requirements
Module: axi_burst_addr_gen

Interface
REQ-001 SHALL have parameter BUS_BYTES, default 4, data-bus width in bytes; legal values 4 only, matching axi_wstrb_t.
REQ-002 SHALL have port aclk  input  1  clock; all state on rising edge.
REQ-003 SHALL have port areset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted this cycle when both cmd_valid and cmd_ready are high.
REQ-006 SHALL have port cmd_addr  input  32  start address (axi_addr_t), unaligned allowed.
REQ-007 SHALL have port cmd_len  input  8  beats minus one (axi_length_t).
REQ-008 SHALL have port cmd_size  input  3  bytes per beat (axi_size_e).
REQ-009 SHALL have port cmd_burst  input  2  burst type (axi_burst_e).
REQ-010 SHALL have port cmd_id  input  4  transaction id (axi_mid_t).
REQ-011 SHALL have port beat_valid  output  1  beat present.
REQ-012 SHALL have port beat_ready  input  1  downstream accepts beat.
REQ-013 SHALL have ports beat_addr (output, 32) and beat_strb (output, 4), giving the per-beat address and byte lanes.
REQ-014 SHALL have ports beat_id (output, 4), beat_idx (output, 8, 0-based) and beat_last (output, 1).
REQ-015 SHALL have port cmd_err  output  1  current command violates a protocol rule.

Function
REQ-016 SHALL implement FSM IDLE/BURST; cmd_ready = 1 only in IDLE; IDLE->BURST on command handshake.
REQ-017 SHALL raise beat_valid the cycle after the command handshake (latency 1) and hold it in BURST.
REQ-018 SHALL hold all beat_* outputs and cmd_err stable while beat_valid=1 and beat_ready=0.
REQ-019 SHALL advance beat on beat_valid&&beat_ready; on the beat_last handshake go to IDLE (one-cycle bubble between bursts).
REQ-020 SHALL assert beat_last exactly when beat_idx == captured len.
REQ-021 SHALL output cmd_addr unchanged for beat 0 in all burst types.
REQ-022 SHALL for FIXED output cmd_addr on every beat.
REQ-023 SHALL for INCR output, for beat N>=1, aligned + N*2^size, where aligned = addr & ~(2^size-1); arithmetic is modulo 2^32.
REQ-024 SHALL for WRAP use wrap_bytes=(len+1)<<size and lower=addr & ~(wrap_bytes-1); next=prev+2^size, replaced by lower when equal to lower+wrap_bytes.
REQ-025 SHALL set beat_strb bits from the beat's address lane (addr mod BUS_BYTES) up to the last lane of its aligned 2^size container; remaining bits 0.
REQ-026 SHALL set cmd_err for: 2^size > BUS_BYTES; burst=2'b11; WRAP with len not in {1,3,7,15}; WRAP with unaligned addr; FIXED with len>15.
REQ-027 SHALL still generate len+1 beats on error; reserved burst handled as INCR; on size error, beat_strb is masked to BUS_BYTES lanes.
REQ-028 SHALL hold cmd_err constant for all beats of the command.

Reset
REQ-029 SHALL on areset immediately enter IDLE with cmd_ready=0 while areset is high and 1 after release.
REQ-030 SHALL on areset drive beat_valid, beat_last and cmd_err to 0 and beat_addr/strb/id/idx to 0.
REQ-031 SHALL on reset mid-burst discard the burst and emit no further beats of it.

Configuration
REQ-032 SHALL, when AXI_ADDR_GEN_4KB_CHECK_EN is defined, also set cmd_err for an INCR burst whose last byte lies in a different 4KB page than cmd_addr.
REQ-033 SHALL, when AXI_ADDR_GEN_4KB_CHECK_EN is undefined, omit the 4KB check, leaving all other behaviour identical.

Structure
REQ-034 SHALL use axi_addr_t, axi_length_t, axi_size_e, axi_burst_e, axi_wstrb_t and axi_mid_t from axi_defination_pkg, and add constant AXI_4KB_BOUNDARY=4096 there.
REQ-035 SHALL keep the FSM state enum local to the module.
REQ-036 SHALL place strobe decode in combinational sub-module axi_strb_calc (inputs: addr lane, size; output: strb).

Verification
REQ-037 SHALL cover INCR 0x1000 len3 size4B: addr 0x1000,0x1004,0x1008,0x100C, strb 0xF, last on idx3, err 0.
REQ-038 SHALL cover WRAP 0x1008 len3 size4B: addr 0x1008,0x100C,0x1000,0x1004, err 0; WRAP len2: err 1, 3 beats.
REQ-039 SHALL cover INCR 0x1001 len1 size4B (strb 0xE then 0xF at 0x1004) and FIXED 0x22 len2 size1B (addr 0x22 x3, strb 0x4).
REQ-040 SHALL cover INCR 0x0FF8 len3 size4B: err 1 with AXI_ADDR_GEN_4KB_CHECK_EN and 0 without, 4 beats either way.
REQ-041 SHALL cover beat_ready low 5 cycles mid-burst (outputs frozen), and areset at beat 2 (beat_valid 0 next, cmd_ready 1 after release).
